// File: rtl/load_sequencer_pkg.sv
// Shared load-op encodings and address-classification helpers for the load sequencer.
// Op encodings follow the RISC-V funct3 field so the decoder can pass it straight through.
package load_sequencer_pkg;

  localparam int LOAD_OP_WIDTH = 3;

  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = 3'b000;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = 3'b001;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = 3'b010;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = 3'b100;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = 3'b101;

  function automatic logic op_known(input logic [LOAD_OP_WIDTH-1:0] op);
    return (op == LOAD_OP_LB) || (op == LOAD_OP_LH) || (op == LOAD_OP_LW) ||
           (op == LOAD_OP_LBU) || (op == LOAD_OP_LHU);
  endfunction

  function automatic logic op_is_half(input logic [LOAD_OP_WIDTH-1:0] op);
    return (op == LOAD_OP_LH) || (op == LOAD_OP_LHU);
  endfunction

  // A load needs a second word only when its bytes spill past the end of the first word.
  function automatic logic needs_two_reads(input logic [LOAD_OP_WIDTH-1:0] op,
                                           input logic [1:0] byte_off);
    return ((op == LOAD_OP_LW) && (byte_off != 2'd0)) ||
           (op_is_half(op) && (byte_off == 2'd3));
  endfunction

  function automatic logic is_misaligned(input logic [LOAD_OP_WIDTH-1:0] op,
                                         input logic [1:0] byte_off);
    return ((op == LOAD_OP_LW) && (byte_off != 2'd0)) ||
           (op_is_half(op) && byte_off[0]);
  endfunction

endpackage

// File: rtl/load_merge_extend.sv
// Combinational merge of two bus words, byte-lane extraction and sign/zero extension.
module load_merge_extend
  import load_sequencer_pkg::*;
(
  input  logic [63:0]              words,
  input  logic [1:0]               byte_off,
  input  logic [LOAD_OP_WIDTH-1:0] op,
  output logic [31:0]              result
);

  logic [31:0] shifted;

  assign shifted = 32'(words >> {byte_off, 3'b000});

  always_comb begin
    result = '0;
    case (op)
      LOAD_OP_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
      LOAD_OP_LBU: result = {24'h0, shifted[7:0]};
      LOAD_OP_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
      LOAD_OP_LHU: result = {16'h0, shifted[15:0]};
      LOAD_OP_LW:  result = shifted;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/load_sequencer.sv
// Multicycle load sequencer: one load at a time, one or two word reads on the bus,
// merged and extended into a registered one-cycle response.
module load_sequencer
  import load_sequencer_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [LOAD_OP_WIDTH-1:0] req_loadop,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     rsp_misaligned,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  input  logic [31:0]              mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t                   state, state_next;
  logic [31:0]              addr_q;
  logic [LOAD_OP_WIDTH-1:0] op_q;
  logic                     two_q;
  logic [31:0]              w0_q;
  logic                     two_in, mis_in, flag_mis;
  logic [31:0]              word_base;
  logic [63:0]              merge_words;
  logic [31:0]              merged;

  assign two_in    = needs_two_reads(req_loadop, req_addr[1:0]);
  assign mis_in    = is_misaligned(req_loadop, req_addr[1:0]);
  assign flag_mis  = !SPLIT_EN && mis_in;
  assign word_base = {addr_q[31:2], 2'b00};

  // The final word arrives straight off the bus so the response can register on that same edge.
  assign merge_words = (state == RD1) ? {mem_rdata, w0_q} : {32'h0, mem_rdata};

  load_merge_extend u_merge (
    .words    (merge_words),
    .byte_off (addr_q[1:0]),
    .op       (op_q),
    .result   (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (flag_mis || !op_known(req_loadop)) state_next = RESP;
          else                                   state_next = RD0;
        end
      end
      RD0: begin
        mem_valid = 1'b1;
        mem_addr  = word_base;
        if (mem_ready) state_next = two_q ? RD1 : RESP;
      end
      RD1: begin
        mem_valid = 1'b1;
        mem_addr  = word_base + 32'd4;
        if (mem_ready) state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response fields only change on the edge that enters RESP, so they hold between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      op_q           <= '0;
      two_q          <= 1'b0;
      w0_q           <= '0;
      rsp_data       <= '0;
      rsp_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            op_q   <= req_loadop;
            two_q  <= two_in;
            if (flag_mis || !op_known(req_loadop)) begin
              rsp_data       <= '0;
              rsp_misaligned <= flag_mis;
            end
          end
        end
        RD0: begin
          if (mem_ready) begin
            w0_q <= mem_rdata;
            if (!two_q) begin
              rsp_data       <= merged;
              rsp_misaligned <= 1'b0;
            end
          end
        end
        RD1: begin
          if (mem_ready) begin
            rsp_data       <= merged;
            rsp_misaligned <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
